// File: rtl/rv32_execute_md.sv
// RV32/RV64 M-extension execute unit: forwarded operands, a multi-cycle multiply,
// a radix-2 restoring divider, and a one-cycle DONE result slot.
module rv32_execute_md #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int FORWARD_EN  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_in,
  input  logic            flush_in,
  input  logic [2:0]      md_op_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [4:0]      ex_rd_in,
  input  logic            ex_rd_writeback_in,
  input  logic [XLEN-1:0] ex_rd_value_in,
  input  logic [4:0]      wb_rd_in,
  input  logic            wb_rd_writeback_in,
  input  logic [XLEN-1:0] wb_rd_value_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic            rd_writeback_out,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e            state_q,    state_d;
  logic [1:0]        op_q,       op_d;
  logic [4:0]        rd_q,       rd_d;
  logic [XLEN-1:0]   opa_q,      opa_d;
  logic [XLEN-1:0]   opb_q,      opb_d;
  logic [XLEN-1:0]   rem_q,      rem_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic              neg_quo_q,  neg_quo_d;
  logic              neg_rem_q,  neg_rem_d;
  logic [XLEN-1:0]   result_q,   result_d;
  logic [4:0]        rd_out_q,   rd_out_d;

  // EX result wins over WB result; x0 is never forwarded.
  function automatic logic [XLEN-1:0] forward_operand(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_value,
    input logic [4:0]      ex_rd,
    input logic            ex_wb,
    input logic [XLEN-1:0] ex_value,
    input logic [4:0]      wb_rd,
    input logic            wb_wb,
    input logic [XLEN-1:0] wb_value
  );
    logic [XLEN-1:0] v;
    v = rf_value;
    if (FORWARD_EN != 0 && idx != 5'd0) begin
      if (ex_wb && ex_rd == idx)      v = ex_value;
      else if (wb_wb && wb_rd == idx) v = wb_value;
    end
    return v;
  endfunction

  logic [XLEN-1:0] a_fwd, b_fwd, a_mag, b_mag, special_res;
  logic            div_signed_in, a_neg, b_neg, div_zero, div_ovf;

  always_comb begin
    a_fwd = forward_operand(rs1_in, rs1_value_in, ex_rd_in, ex_rd_writeback_in,
                            ex_rd_value_in, wb_rd_in, wb_rd_writeback_in, wb_rd_value_in);
    b_fwd = forward_operand(rs2_in, rs2_value_in, ex_rd_in, ex_rd_writeback_in,
                            ex_rd_value_in, wb_rd_in, wb_rd_writeback_in, wb_rd_value_in);
    div_signed_in = ~md_op_in[0];
    a_neg         = div_signed_in & a_fwd[XLEN-1];
    b_neg         = div_signed_in & b_fwd[XLEN-1];
    a_mag         = a_neg ? -a_fwd : a_fwd;
    b_mag         = b_neg ? -b_fwd : b_fwd;
    div_zero      = (b_fwd == '0);
    div_ovf       = div_signed_in & (a_fwd == MOST_NEG) & (b_fwd == '1);
    // bit 1 of the op selects remainder over quotient
    if (div_zero) special_res = md_op_in[1] ? a_fwd : '1;
    else          special_res = md_op_in[1] ? '0    : a_fwd;
  end

  // Operands are zero/sign-extended to 2*XLEN so a plain truncating multiply
  // yields the exact double-width product for every signedness mix.
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a_sgn = (op_q != 2'b11);
    mul_b_sgn = ~op_q[1];
    mul_a_ext = {{XLEN{mul_a_sgn & opa_q[XLEN-1]}}, opa_q};
    mul_b_ext = {{XLEN{mul_b_sgn & opb_q[XLEN-1]}}, opb_q};
    mul_prod  = mul_a_ext * mul_b_ext;
    mul_res   = (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  // One restoring step: opa_q shifts the dividend out and the quotient in.
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_fits;
  logic [XLEN-1:0] quo_nx, rem_nx, quo_fix, rem_fix, div_res;

  always_comb begin
    div_shift = {rem_q, opa_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_fits  = ~div_diff[XLEN];
    rem_nx    = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_nx    = {opa_q[XLEN-2:0], div_fits};
    quo_fix   = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix   = neg_rem_q ? -rem_nx : rem_nx;
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    // NOTE: every *_d starts at its held value so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;

    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            op_d  = md_op_in[1:0];
            rd_d  = rd_in;
            cnt_d = '0;
            if (!md_op_in[2]) begin
              opa_d   = a_fwd;
              opb_d   = b_fwd;
              state_d = S_MUL;
            end else if (div_zero || div_ovf) begin
              result_d = special_res;
              rd_out_d = rd_in;
              state_d  = S_DONE;
            end else begin
              opa_d     = a_mag;
              opb_d     = b_mag;
              rem_d     = '0;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              state_d   = S_DIV;
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == MUL_LAST) begin
            result_d = mul_res;
            rd_out_d = rd_q;
            state_d  = S_DONE;
          end
        end
        S_DIV: begin
          opa_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == DIV_LAST) begin
            result_d = div_res;
            rd_out_d = rd_q;
            state_d  = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // Stall is gated by reset so an upstream valid cannot stall a block in reset.
  assign stall_out        = reset_n & ((state_q == S_MUL) | (state_q == S_DIV) |
                                       ((state_q == S_IDLE) & valid_in));
  assign valid_out        = (state_q == S_DONE) & ~flush_in;
  assign rd_writeback_out = valid_out & (rd_out_q != 5'd0);
  assign result_out       = result_q;
  assign rd_out           = rd_out_q;

endmodule

// File: tb/tb_rv32_execute_md.sv
// Self-checking bench for rv32_execute_md: directed spot checks with literal
// expectations plus random traffic compared every cycle against a transaction model.
module tb_rv32_execute_md;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0, flush_in = 1'b0;
  logic [2:0]  md_op_in = '0;
  logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
  logic [31:0] rs1_value_in = '0, rs2_value_in = '0;
  logic [4:0]  ex_rd_in = '0, wb_rd_in = '0;
  logic        ex_rd_writeback_in = 1'b0, wb_rd_writeback_in = 1'b0;
  logic [31:0] ex_rd_value_in = '0, wb_rd_value_in = '0;

  logic        stall_out, valid_out, rd_writeback_out;
  logic [4:0]  rd_out;
  logic [31:0] result_out;
  logic        nf_stall_out, nf_valid_out, nf_rd_writeback_out;
  logic [4:0]  nf_rd_out;
  logic [31:0] nf_result_out;

  always #5 clk = ~clk;

  rv32_execute_md #(.XLEN(32), .MUL_LATENCY(2), .FORWARD_EN(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush_in(flush_in),
    .md_op_in(md_op_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .ex_rd_in(ex_rd_in), .ex_rd_writeback_in(ex_rd_writeback_in), .ex_rd_value_in(ex_rd_value_in),
    .wb_rd_in(wb_rd_in), .wb_rd_writeback_in(wb_rd_writeback_in), .wb_rd_value_in(wb_rd_value_in),
    .stall_out(stall_out), .valid_out(valid_out), .rd_out(rd_out),
    .rd_writeback_out(rd_writeback_out), .result_out(result_out)
  );

  rv32_execute_md #(.XLEN(32), .MUL_LATENCY(2), .FORWARD_EN(0)) u_nf (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush_in(flush_in),
    .md_op_in(md_op_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .ex_rd_in(ex_rd_in), .ex_rd_writeback_in(ex_rd_writeback_in), .ex_rd_value_in(ex_rd_value_in),
    .wb_rd_in(wb_rd_in), .wb_rd_writeback_in(wb_rd_writeback_in), .wb_rd_value_in(wb_rd_value_in),
    .stall_out(nf_stall_out), .valid_out(nf_valid_out), .rd_out(nf_rd_out),
    .rd_writeback_out(nf_rd_writeback_out), .result_out(nf_result_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a;
            else return 32'(int'(a) / int'(b));
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'h0;
            else return 32'(int'(a) % int'(b));
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx != 0 && ex_rd_writeback_in && ex_rd_in == idx) return ex_rd_value_in;
    if (idx != 0 && wb_rd_writeback_in && wb_rd_in == idx) return wb_rd_value_in;
    return rf;
  endfunction

  // ---------------- transaction model + per-cycle compare ----------------
  int          m_remain = 0;
  bit          m_done = 0;
  logic [31:0] m_pend = '0, m_show = '0;
  logic [4:0]  m_pend_rd = '0, m_show_rd = '0;

  always @(negedge clk) begin
    logic        exp_valid, exp_stall;
    logic [31:0] a, b;
    int          lat;
    if (!reset_n) begin
      m_remain = 0; m_done = 0; m_show = '0; m_show_rd = '0;
    end
    exp_valid = m_done && !flush_in;
    exp_stall = reset_n && (m_remain > 0 || (!m_done && valid_in));
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("stall_out", 32'(stall_out), 32'(exp_stall));
    check("result_out", result_out, m_show);
    check("rd_out", 32'(rd_out), 32'(m_show_rd));
    check("rd_writeback_out", 32'(rd_writeback_out), 32'(exp_valid && m_show_rd != 0));
    if (reset_n) begin
      if (m_done) begin
        m_done = 0;
      end else if (m_remain > 0) begin
        if (flush_in) m_remain = 0;
        else begin
          m_remain--;
          if (m_remain == 0) begin m_done = 1; m_show = m_pend; m_show_rd = m_pend_rd; end
        end
      end else if (valid_in && !flush_in) begin
        a         = fwd(rs1_in, rs1_value_in);
        b         = fwd(rs2_in, rs2_value_in);
        m_pend    = ref_md(md_op_in, a, b);
        m_pend_rd = rd_in;
        lat       = ref_latency(md_op_in, a, b);
        if (lat == 0) begin m_done = 1; m_show = m_pend; m_show_rd = m_pend_rd; end
        else m_remain = lat;
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [31:0] nf_res;

  task automatic do_op(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res, output int stalls);
    logic got;
    @(posedge clk); #1;
    valid_in = 1'b1; md_op_in = op; rs1_in = r1; rs2_in = r2; rd_in = rd;
    rs1_value_in = a; rs2_value_in = b;
    @(negedge clk);
    stalls = int'(stall_out);
    lat    = 0;
    do begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      lat++;
      @(negedge clk);
      got = valid_out;
      if (!got) stalls += int'(stall_out);
    end while (!got && lat < 100);
    check("done_seen", 32'(valid_out), 32'd1);
    check("done_stall_low", 32'(stall_out), 32'd0);
    res    = result_out;
    nf_res = nf_result_out;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int          lat, stalls, v, cyc, npulse, d1, d2, which;
    logic [31:0] res, r1, r2, saved;
    bit          consumed;

    @(negedge clk);
    check("reset_result", result_out, 32'h0);
    check("reset_valid", 32'(valid_out), 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;

    // forwarding: EX beats WB, x0 never forwarded, FORWARD_EN=0 uses the register file
    ex_rd_in = 5'd5; ex_rd_writeback_in = 1'b1; ex_rd_value_in = 32'd9;
    wb_rd_in = 5'd5; wb_rd_writeback_in = 1'b1; wb_rd_value_in = 32'd4;
    do_op(3'd3, 5'd5, 5'd6, 32'd6, 32'h8000_0000, 5'd7, lat, res, stalls);
    check("fwd_ex_result", res, 32'd4);
    check("fwd_off_result", nf_res, 32'd3);
    ex_rd_writeback_in = 1'b0;
    do_op(3'd3, 5'd5, 5'd6, 32'd6, 32'h8000_0000, 5'd7, lat, res, stalls);
    check("fwd_wb_result", res, 32'd2);
    ex_rd_in = 5'd0; ex_rd_writeback_in = 1'b1; wb_rd_in = 5'd0;
    do_op(3'd3, 5'd0, 5'd6, 32'd6, 32'h8000_0000, 5'd7, lat, res, stalls);
    check("fwd_x0_result", res, 32'd3);
    ex_rd_writeback_in = 1'b0; wb_rd_writeback_in = 1'b0;

    do_op(3'd0, 5'd1, 5'd2, 32'd7, 32'hFFFF_FFFD, 5'd3, lat, res, stalls);
    check("mul_latency", 32'(lat), 32'd3);
    check("mul_result", res, 32'hFFFF_FFEB);
    check("mul_stall_cycles", 32'(stalls), 32'd3);

    do_op(3'd4, 5'd1, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, res, stalls);
    check("div_ovf_latency", 32'(lat), 32'd1);
    check("div_ovf_result", res, 32'h8000_0000);
    do_op(3'd6, 5'd1, 5'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, lat, res, stalls);
    check("rem_ovf_result", res, 32'h0);
    do_op(3'd5, 5'd1, 5'd2, 32'd5, 32'd0, 5'd3, lat, res, stalls);
    check("divu_zero_latency", 32'(lat), 32'd1);
    check("divu_zero_result", res, 32'hFFFF_FFFF);
    do_op(3'd7, 5'd1, 5'd2, 32'd5, 32'd0, 5'd3, lat, res, stalls);
    check("remu_zero_result", res, 32'd5);

    do_op(3'd4, 5'd1, 5'd2, -32'd20, 32'd6, 5'd3, lat, res, stalls);
    check("div_latency", 32'(lat), 32'd33);
    check("div_result", res, 32'hFFFF_FFFD);
    check("div_stall_cycles", 32'(stalls), 32'd33);
    do_op(3'd6, 5'd1, 5'd2, -32'd20, 32'd6, 5'd0, lat, res, stalls);
    check("rem_result", res, 32'hFFFF_FFFE);
    check("rd0_no_writeback", 32'(rd_writeback_out), 32'd0);

    // flush in the middle of a divide
    saved = result_out;
    @(posedge clk); #1;
    valid_in = 1'b1; md_op_in = 3'd4; rs1_in = 5'd1; rs2_in = 5'd2; rd_in = 5'd9;
    rs1_value_in = 32'd1000; rs2_value_in = 32'd7;
    @(posedge clk); #1 valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk);
    check("flush_div_idle", 32'(stall_out), 32'd0);
    v = 0;
    repeat (40) begin @(negedge clk); v += int'(valid_out); end
    check("flush_div_no_valid", 32'(v), 32'd0);
    check("flush_div_result_held", result_out, saved);

    // flush during DONE
    @(posedge clk); #1;
    valid_in = 1'b1; md_op_in = 3'd0; rs1_value_in = 32'd6; rs2_value_in = 32'd7; rd_in = 5'd3;
    @(posedge clk); #1 valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush_in = 1'b1;
    @(negedge clk);
    check("flush_done_valid", 32'(valid_out), 32'd0);
    check("flush_done_wb", 32'(rd_writeback_out), 32'd0);
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk);
    check("flush_done_idle", 32'(stall_out), 32'd0);

    // back-to-back MUL then DIVU with valid held
    @(posedge clk); #1;
    valid_in = 1'b1; md_op_in = 3'd0; rs1_value_in = 32'd6; rs2_value_in = 32'd7; rd_in = 5'd3;
    cyc = 0; npulse = 0; d1 = -1; d2 = -1; which = 0; r1 = '0; r2 = '0;
    while (cyc < 200 && npulse < 2) begin
      @(negedge clk);
      if (valid_out) begin
        if (npulse == 0) begin r1 = result_out; d1 = cyc; end
        else begin r2 = result_out; d2 = cyc; end
        npulse++;
      end
      consumed = valid_in && !stall_out;
      @(posedge clk); #1;
      cyc++;
      if (consumed) begin
        if (which == 0) begin
          which = 1; md_op_in = 3'd5; rs1_value_in = 32'd100; rs2_value_in = 32'd7; rd_in = 5'd4;
        end else valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_mul_result", r1, 32'd42);
    check("b2b_divu_result", r2, 32'd14);
    check("b2b_spacing", 32'(d2 - d1), 32'd34);

    // reset pulsed mid-MUL
    @(posedge clk); #1;
    valid_in = 1'b1; md_op_in = 3'd0; rs1_value_in = 32'd7; rs2_value_in = 32'd9; rd_in = 5'd5;
    @(posedge clk); #1 valid_in = 1'b0;
    #1 reset_n = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    #1 valid_in = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    v = 0;
    repeat (10) begin @(negedge clk); v += int'(valid_out); end
    check("rst_no_valid", 32'(v), 32'd0);

    // random traffic; the per-cycle model checks everything
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      valid_in           = ($urandom_range(0, 9) < 7);
      md_op_in           = 3'($urandom_range(0, 7));
      rs1_in             = 5'($urandom_range(0, 7));
      rs2_in             = 5'($urandom_range(0, 7));
      rd_in              = 5'($urandom_range(0, 7));
      rs1_value_in       = rand_val();
      rs2_value_in       = rand_val();
      ex_rd_in           = 5'($urandom_range(0, 7));
      ex_rd_writeback_in = 1'($urandom_range(0, 1));
      ex_rd_value_in     = rand_val();
      wb_rd_in           = 5'($urandom_range(0, 7));
      wb_rd_writeback_in = 1'($urandom_range(0, 1));
      wb_rd_value_in     = rand_val();
      flush_in           = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; flush_in = 1'b0; ex_rd_writeback_in = 1'b0; wb_rd_writeback_in = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_execute_md.md
RV32_EXECUTE_MD -- requirements
Module: rv32_execute_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 Parameter MUL_LATENCY, default 2, cycles spent in MUL state; legal values 1..4.
REQ-003 Parameter FORWARD_EN, default 1; 0 disables both forwarding paths, so operands come only from the register-file values.
REQ-004 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port valid_in  in  1  M-extension instruction presented.
REQ-007 Port flush_in  in  1  synchronous kill of any in-flight operation.
REQ-008 Port md_op_in  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 Port rs1_in, rs2_in, rd_in  in  5 each  source and destination register indices.
REQ-010 Port rs1_value_in, rs2_value_in  in  XLEN each  register-file operand values.
REQ-011 Port ex_rd_in  in  5; ex_rd_writeback_in  in  1; ex_rd_value_in  in  XLEN  forwarding source 0, from the ALU result.
REQ-012 Port wb_rd_in  in  5; wb_rd_writeback_in  in  1; wb_rd_value_in  in  XLEN  forwarding source 1, from writeback.
REQ-013 Port stall_out  out  1  upstream holds its instruction while high.
REQ-014 Port valid_out  out  1  result_out is valid this cycle.
REQ-015 Port rd_out  out  5; rd_writeback_out  out  1; result_out  out  XLEN  result and destination register.

Function
REQ-016 Operand forwarding SHALL be evaluated per source independently, in this priority order:
- source 0 when ex_rd_writeback_in is high, ex_rd_in equals the index, and the index is non-zero;
- otherwise source 1 under the same rule;
- otherwise the register-file value.
REQ-017 States SHALL be IDLE, MUL, DIV and DONE.
REQ-018 Accept SHALL occur when valid_in is high in IDLE; forwarded operands, md_op_in and rd_in are latched on that edge.
REQ-019 On accept, state SHALL transition as follows:
- md_op_in 0-3 -> MUL;
- md_op_in 4-7 without a special case -> DIV;
- divide special case -> DONE.
REQ-020 MUL SHALL last exactly MUL_LATENCY cycles, then transition to DONE.
REQ-021 DIV SHALL be a restoring radix-2 divide of exactly XLEN cycles on operand magnitudes, with sign correction applied on entry to DONE, then transition to DONE.
REQ-022 DONE SHALL last one cycle, then transition to IDLE; a new accept is possible in the cycle after DONE.
REQ-023 stall_out SHALL be high when state is MUL or DIV, or when state is IDLE and valid_in is high; it SHALL be low in DONE, and low in IDLE without valid_in.
REQ-024 valid_out SHALL equal (state==DONE) AND NOT flush_in.
REQ-025 rd_writeback_out SHALL equal valid_out AND (rd_out != 0).
REQ-026 Multiply results SHALL be taken from the 2*XLEN product:
- MUL returns the low XLEN bits;
- MULH returns the high XLEN bits, signed x signed;
- MULHSU returns the high XLEN bits, signed x unsigned;
- MULHU returns the high XLEN bits, unsigned x unsigned.
REQ-027 Divide by zero SHALL return quotient all-ones and remainder = dividend, for both signed and unsigned ops; latency is accept -> DONE in 1 cycle.
REQ-028 Signed overflow (dividend = most-negative, divisor = -1) SHALL return quotient = dividend and remainder = 0, with 1-cycle latency.
REQ-029 Signed divide SHALL round the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-030 flush_in SHALL force IDLE on the next edge from any state, abandon any partial result, and take priority over accept in the same cycle.
REQ-031 result_out and rd_out SHALL hold their last values outside DONE; they are don't-care for consumers while valid_out is low.

Reset
REQ-032 While reset_n is low, the block SHALL asynchronously set:
- state = IDLE;
- valid_out, rd_writeback_out and stall_out = 0 (stall_out follows valid_in once reset is released);
- result_out = 0 and rd_out = 0;
- iteration counter and internal operand registers = 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation; no valid_out follows reset release.

Verification
REQ-034 MUL, rs1=7, rs2=-3, MUL_LATENCY=2, accept at cycle 0 -> valid_out at cycle 3, result_out=0xFFFFFFEB, stall_out low only in cycle 3.
REQ-035 DIV, 0x80000000 / 0xFFFFFFFF -> valid_out 1 cycle after accept, result 0x80000000; REM on the same operands -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-036 DIV -20/6 -> result -3 at accept+XLEN+1 cycles; REM -20/6 -> -2; stall_out high for all XLEN+1 cycles before DONE.
REQ-037 rs1=5 with ex_rd=5/writeback=1 (value 9) and wb_rd=5/writeback=1 (value 4), MULHU by 2^31 -> operand 9 used, result 4; repeated with rs1=0 -> register value used; FORWARD_EN=0 -> register value used.
REQ-038 flush_in at DIV iteration 10 -> IDLE next cycle, no valid_out; flush_in during DONE -> valid_out low; reset_n pulsed mid-MUL -> all outputs 0 and no later valid_out.
REQ-039 Back-to-back MUL then DIVU 100/7 with valid_in held -> two valid_out pulses, results correct (DIVU result 14), second accept the cycle after the first DONE.
